// File: rtl/fpu_f32_to_int_scheduler.sv
// rtl/fpu_f32_to_int_scheduler.sv - round-robin shared f32->int32 converter with elastic tagged result pipeline; optional O_EXCEPT via FPU_CVT_EXCEPT_EN
module fpu_f32_to_int_scheduler #(
  parameter  int CH_COUNT = 4,
  parameter  int STAGES   = 2,
  localparam int ID_W     = $clog2(CH_COUNT)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CH_COUNT-1:0]   REQ_VALID,
  output logic [CH_COUNT-1:0]   REQ_READY,
  input  logic [32*CH_COUNT-1:0] REQ_DATA,
  input  logic                  FLUSH,
  output logic                  O_VALID,
  input  logic                  O_READY,
  output logic [ID_W-1:0]       O_ID,
  output logic [31:0]           O_DATA,
  output logic                  BUSY
`ifdef FPU_CVT_EXCEPT_EN
  ,
  output logic                  O_EXCEPT
`endif
);

  localparam logic [ID_W:0]   CH_CNT_W = (ID_W + 1)'(CH_COUNT);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(CH_COUNT - 1);

  // Truncate-toward-zero conversion; NaN, Inf and anything with |x| >= 2^31
  // return the integer-indefinite value 0x80000000 (which is also the exact
  // result for -2^31).
  function automatic logic [31:0] f32_to_int(input logic [31:0] f);
    logic [7:0]  e;
    logic [31:0] mag;
    logic [31:0] res;
    e   = f[30:23];
    mag = {8'h00, 1'b1, f[22:0]};
    if (e >= 8'd158) begin
      res = 32'h8000_0000;
    end else if (e < 8'd127) begin
      res = 32'h0000_0000;
    end else begin
      if (e >= 8'd150) begin
        mag = mag << (e - 8'd150);
      end else begin
        mag = mag >> (8'd150 - e);
      end
      res = f[31] ? (32'h0 - mag) : mag;
    end
    return res;
  endfunction

`ifdef FPU_CVT_EXCEPT_EN
  // Flags operands whose result is not a faithful truncation of the input.
  function automatic logic f32_to_int_except(input logic [31:0] f);
    logic [7:0] e;
    e = f[30:23];
    return (e == 8'hFF) | ((e >= 8'd158) & (f != 32'hCF00_0000));
  endfunction
`endif

  logic [ID_W-1:0]     rr_q, rr_d;
  logic [STAGES-1:0]   v_q, v_d;
  logic [ID_W-1:0]     id_q   [STAGES];
  logic [31:0]         data_q [STAGES];
`ifdef FPU_CVT_EXCEPT_EN
  logic                exc_q  [STAGES];
`endif

  logic [CH_COUNT-1:0] grant_oh;
  logic [ID_W-1:0]     grant_id;
  logic                grant_any;
  logic [ID_W:0]       idx_w;
  logic [ID_W-1:0]     idx;
  logic [31:0]         sel_data;
  logic [31:0]         cvt_data;
  logic [STAGES-1:0]   adv;
  logic                full_above;
  logic                accept0;
  logic                handshake;

  // Round-robin search starting at the pointer, wrapping past the last channel.
  always_comb begin
    grant_oh  = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx_w     = '0;
    idx       = '0;
    for (int k = 0; k < CH_COUNT; k++) begin
      idx_w = {1'b0, rr_q} + (ID_W + 1)'(k);
      if (idx_w >= CH_CNT_W) begin
        idx_w = idx_w - CH_CNT_W;
      end
      idx = idx_w[ID_W-1:0];
      if (!grant_any && REQ_VALID[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
    grant_oh[grant_id] = grant_any;
  end

  // Operand mux for the granted channel.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CH_COUNT; i++) begin
      if (grant_any && (grant_id == ID_W'(i))) begin
        sel_data = REQ_DATA[32*i +: 32];
      end
    end
  end

  assign cvt_data = f32_to_int(sel_data);

  // A stage moves on when the last stage drains or any later stage has a bubble.
  always_comb begin
    adv        = '0;
    full_above = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      full_above = 1'b1;
      for (int j = i + 1; j < STAGES; j++) begin
        full_above = full_above & v_q[j];
      end
      adv[i] = v_q[i] & (O_READY | ~full_above);
    end
  end

  assign accept0   = ~v_q[0] | adv[0];
  assign handshake = grant_any & accept0 & ~FLUSH & ~RST;
  assign REQ_READY = (accept0 & ~FLUSH & ~RST) ? grant_oh : '0;

  // Next-state of the stage valids and the round-robin pointer.
  always_comb begin
    v_d = v_q;
    if (FLUSH) begin
      v_d = '0;
    end else begin
      v_d[0] = (v_q[0] & ~adv[0]) | handshake;
      for (int i = 1; i < STAGES; i++) begin
        v_d[i] = (v_q[i] & ~adv[i]) | adv[i-1];
      end
    end
    rr_d = rr_q;
    if (handshake) begin
      rr_d = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
    end
  end

  // Pipeline registers: control, tags and converted results.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_q <= '0;
      v_q  <= '0;
      for (int i = 0; i < STAGES; i++) begin
        id_q[i]   <= '0;
        data_q[i] <= '0;
`ifdef FPU_CVT_EXCEPT_EN
        exc_q[i]  <= 1'b0;
`endif
      end
    end else begin
      rr_q <= rr_d;
      v_q  <= v_d;
      if (handshake) begin
        id_q[0]   <= grant_id;
        data_q[0] <= cvt_data;
`ifdef FPU_CVT_EXCEPT_EN
        exc_q[0]  <= f32_to_int_except(sel_data);
`endif
      end
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i-1]) begin
          id_q[i]   <= id_q[i-1];
          data_q[i] <= data_q[i-1];
`ifdef FPU_CVT_EXCEPT_EN
          exc_q[i]  <= exc_q[i-1];
`endif
        end
      end
    end
  end

  assign O_VALID  = v_q[STAGES-1];
  assign O_ID     = id_q[STAGES-1];
  assign O_DATA   = data_q[STAGES-1];
  assign BUSY     = |v_q;
`ifdef FPU_CVT_EXCEPT_EN
  assign O_EXCEPT = exc_q[STAGES-1];
`endif

endmodule

// File: tb/tb_fpu_f32_to_int_scheduler.sv
// tb/tb_fpu_f32_to_int_scheduler.sv - self-checking bench for fpu_f32_to_int_scheduler
module tb_fpu_f32_to_int_scheduler;

  localparam int CH = 4;
  localparam int ST = 2;

  logic            CLK = 1'b0;
  logic            RST;
  logic [CH-1:0]   REQ_VALID;
  logic [CH-1:0]   REQ_READY;
  logic [32*CH-1:0] REQ_DATA;
  logic            FLUSH;
  logic            O_VALID;
  logic            O_READY;
  logic [1:0]      O_ID;
  logic [31:0]     O_DATA;
  logic            BUSY;
`ifdef FPU_CVT_EXCEPT_EN
  logic            O_EXCEPT;
`endif

  always #5 CLK = ~CLK;

  fpu_f32_to_int_scheduler #(.CH_COUNT(CH), .STAGES(ST)) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ_VALID(REQ_VALID),
    .REQ_READY(REQ_READY),
    .REQ_DATA(REQ_DATA),
    .FLUSH(FLUSH),
    .O_VALID(O_VALID),
    .O_READY(O_READY),
    .O_ID(O_ID),
    .O_DATA(O_DATA),
    .BUSY(BUSY)
`ifdef FPU_CVT_EXCEPT_EN
    ,
    .O_EXCEPT(O_EXCEPT)
`endif
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        exc;
    int          rdy;
  } ent_t;

  ent_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rr_m = 0;
  bit          rst_m = 1'b1;
  logic [CH-1:0] en;
  logic [31:0] pq [CH][64];
  int          ph [CH];
  int          pt [CH];

  logic        obs_ov, obs_busy;
  logic [CH-1:0] obs_rr;
  logic [1:0]  obs_id;
  logic [31:0] obs_data;
  int          dut_hs;
  int          gseq[$];
  logic [1:0]  log_id[$];
  logic [31:0] log_data[$];
  logic        log_exc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference conversion through IEEE double arithmetic.
  function automatic real f32_val(input logic [31:0] f);
    int          e;
    logic [63:0] d;
    e = int'(f[30:23]);
    if (e == 0) return 0.0;
    d = {f[31], 11'(e + 896), f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] m_cvt(input logic [31:0] f);
    real x;
    if (f[30:23] == 8'hFF) return 32'h8000_0000;
    x = f32_val(f);
    if (x >= 2147483648.0 || x <= -2147483648.0) return 32'h8000_0000;
    return 32'($rtoi(x));
  endfunction

  function automatic logic m_exc(input logic [31:0] f);
    real x;
    if (f[30:23] == 8'hFF) return 1'b1;
    x = f32_val(f);
    if (x == -2147483648.0) return 1'b0;
    return (x >= 2147483648.0 || x <= -2147483648.0);
  endfunction

  function automatic bit has(input int ch);
    return ph[ch] != pt[ch];
  endfunction

  task automatic add(input int ch, input logic [31:0] v);
    pq[ch][pt[ch]] = v;
    pt[ch]++;
  endtask

  task automatic drive();
    for (int ch = 0; ch < CH; ch++) begin
      REQ_VALID[ch] = en[ch] && has(ch);
      REQ_DATA[32*ch +: 32] = has(ch) ? pq[ch][ph[ch]] : 32'h0;
    end
  endtask

  // One clock: drive, compare against the model mid-cycle, then advance the model.
  task automatic step();
    int            gm;
    int            ix;
    logic [CH-1:0] exp_rr;
    bit            acc, hs, exp_ov;
    ent_t          e, h;
    drive();
    @(negedge CLK);
    gm = -1;
    if (!rst_m) begin
      for (int k = 0; k < CH; k++) begin
        ix = (rr_m + k) % CH;
        if (gm < 0 && en[ix] && has(ix)) gm = ix;
      end
    end
    acc = O_READY || (sb.size() < ST);
    hs = (gm >= 0) && acc && !FLUSH && !rst_m;
    exp_rr = '0;
    if (hs) exp_rr[gm] = 1'b1;
    exp_ov = !rst_m && (sb.size() > 0) && (sb[0].rdy <= cyc);
    chk("req_ready", 32'(REQ_READY), 32'(exp_rr));
    chk("o_valid", 32'(O_VALID), 32'(exp_ov));
    chk("busy", 32'(BUSY), 32'(!rst_m && sb.size() > 0));
    if (exp_ov) begin
      h = sb[0];
      chk("o_id", 32'(O_ID), 32'(h.id));
      chk("o_data", O_DATA, h.data);
`ifdef FPU_CVT_EXCEPT_EN
      chk("o_except", 32'(O_EXCEPT), 32'(h.exc));
`endif
    end
    obs_ov = O_VALID;
    obs_busy = BUSY;
    obs_rr = REQ_READY;
    obs_id = O_ID;
    obs_data = O_DATA;
    dut_hs += $countones(REQ_READY & REQ_VALID);
    for (int i = 0; i < CH; i++) if (REQ_READY[i]) gseq.push_back(i);
    if (O_VALID && O_READY) begin
      log_id.push_back(O_ID);
      log_data.push_back(O_DATA);
`ifdef FPU_CVT_EXCEPT_EN
      log_exc.push_back(O_EXCEPT);
`else
      log_exc.push_back(1'b0);
`endif
    end
    @(posedge CLK);
    if (!rst_m) begin
      if (FLUSH) begin
        sb.delete();
      end else begin
        if (exp_ov && O_READY) begin
          void'(sb.pop_front());
          if (sb.size() > 0) begin
            h = sb[0];
            if (h.rdy < cyc + 1) h.rdy = cyc + 1;
            sb[0] = h;
          end
        end
        if (hs) begin
          e.id = 2'(gm);
          e.data = m_cvt(pq[gm][ph[gm]]);
          e.exc = m_exc(pq[gm][ph[gm]]);
          e.rdy = cyc + ST;
          sb.push_back(e);
          ph[gm]++;
          rr_m = (gm + 1) % CH;
        end
      end
    end
    cyc++;
    #1;
  endtask

  function automatic bit anypend();
    for (int ch = 0; ch < CH; ch++) if (en[ch] && has(ch)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((sb.size() > 0 || anypend()) && n < max) begin
      step();
      n++;
    end
    if (sb.size() > 0 || anypend()) begin
      chk("drain_timeout", 32'(n), 32'(max + 1));
    end
  endtask

  task automatic clear_logs();
    gseq.delete();
    log_id.delete();
    log_data.delete();
    log_exc.delete();
    dut_hs = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_o_valid"}, 32'(O_VALID), 32'h0);
    chk({tag, "_busy"}, 32'(BUSY), 32'h0);
    chk({tag, "_o_id"}, 32'(O_ID), 32'h0);
    chk({tag, "_o_data"}, O_DATA, 32'h0);
    chk({tag, "_req_ready"}, 32'(REQ_READY), 32'h0);
  endtask

  int gexp[8];

  initial begin
    RST = 1'b1;
    FLUSH = 1'b0;
    O_READY = 1'b1;
    en = '0;
    REQ_VALID = '0;
    REQ_DATA = '0;
    for (int ch = 0; ch < CH; ch++) begin
      ph[ch] = 0;
      pt[ch] = 0;
    end
    clear_logs();
    #2;
    chk_reset_outputs("reset");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    rst_m = 1'b0;

    // 1: single request, latency STAGES
    add(0, 32'h3FC0_0000);
    en = 4'b0001;
    step();
    chk("t1_grant", 32'(obs_rr), 32'h1);
    step();
    chk("t1_busy", 32'(obs_busy), 32'h1);
    chk("t1_valid_early", 32'(obs_ov), 32'h0);
    step();
    chk("t1_valid", 32'(obs_ov), 32'h1);
    chk("t1_id", 32'(obs_id), 32'h0);
    chk("t1_data", obs_data, 32'h0000_0001);
    drain(20);

    // 2: all channels streaming; pointer starts at 1 after the ch0 grant
    clear_logs();
    for (int r = 0; r < 3; r++) begin
      add(0, 32'h3FC0_0000);
      add(1, 32'h42C8_0000);
      add(2, 32'hC020_0000);
      add(3, 32'hCB00_0001);
    end
    en = 4'b1111;
    drain(60);
    gexp = '{1, 2, 3, 0, 1, 2, 3, 0};
    chk("t2_grant_count", 32'(gseq.size()), 32'd12);
    chk("t2_out_count", 32'(log_id.size()), 32'd12);
    if (gseq.size() >= 8 && log_id.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t2_grant_seq", 32'(gseq[i]), 32'(gexp[i]));
        chk("t2_oid_seq", 32'(log_id[i]), 32'(gexp[i]));
      end
    end
    for (int i = 0; i < log_id.size(); i++) begin
      if (log_id[i] == 2'd2) chk("t2_ch2_data", log_data[i], 32'hFFFF_FFFE);
      if (log_id[i] == 2'd1) chk("t2_ch1_data", log_data[i], 32'h0000_0064);
      if (log_id[i] == 2'd3) chk("t2_ch3_data", log_data[i], 32'hFF7F_FFFF);
    end

    // 3: downstream stall from empty
    clear_logs();
    for (int r = 0; r < 2; r++) for (int ch = 0; ch < CH; ch++) add(ch, 32'h4120_0000 + 32'(ch << 20));
    O_READY = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("t3_accepted", 32'(dut_hs), 32'(ST));
    chk("t3_ready_low", 32'(obs_rr), 32'h0);
    chk("t3_valid_held", 32'(obs_ov), 32'h1);
    O_READY = 1'b1;
    drain(60);
    chk("t3_out_count", 32'(log_id.size()), 32'd8);

    // 4: flush with the pipeline full
    clear_logs();
    for (int r = 0; r < 2; r++) for (int ch = 0; ch < CH; ch++) add(ch, 32'hC2F6_0000);
    O_READY = 1'b0;
    for (int i = 0; i < 3; i++) step();
    O_READY = 1'b1;
    FLUSH = 1'b1;
    step();
    chk("t4_ready_in_flush", 32'(obs_rr), 32'h0);
    chk("t4_busy_in_flush", 32'(obs_busy), 32'h1);
    FLUSH = 1'b0;
    step();
    chk("t4_valid_after", 32'(obs_ov), 32'h0);
    chk("t4_busy_after", 32'(obs_busy), 32'h0);
    drain(60);

    // 5: asynchronous reset mid-burst
    for (int r = 0; r < 3; r++) for (int ch = 0; ch < CH; ch++) add(ch, 32'h4480_0000);
    for (int i = 0; i < 3; i++) step();
    #2;
    RST = 1'b1;
    #1;
    chk_reset_outputs("t5_async");
    rst_m = 1'b1;
    sb.delete();
    rr_m = 0;
    step();
    step();
    RST = 1'b0;
    rst_m = 1'b0;
    step();
    chk("t5_first_grant", 32'(obs_rr), 32'h1);
    drain(80);

    // 6: special operands
    clear_logs();
    en = 4'b0001;
    add(0, 32'h7FC0_0000);
    add(0, 32'h4F00_0000);
    add(0, 32'hCF00_0000);
    drain(30);
    en = 4'b0010;
    add(1, 32'h4EFF_FFFF);
    add(1, 32'h7F80_0000);
    add(1, 32'h0000_0001);
    add(1, 32'h8000_0000);
    add(1, 32'h3F7F_FFFF);
    drain(30);
    chk("t6_out_count", 32'(log_data.size()), 32'd8);
    if (log_data.size() == 8) begin
      chk("t6_nan_data", log_data[0], 32'h8000_0000);
      chk("t6_2p31_data", log_data[1], 32'h8000_0000);
      chk("t6_m2p31_data", log_data[2], 32'h8000_0000);
      chk("t6_max_data", log_data[3], 32'h7FFF_FF80);
      chk("t6_inf_data", log_data[4], 32'h8000_0000);
      chk("t6_denorm_data", log_data[5], 32'h0000_0000);
      chk("t6_negzero_data", log_data[6], 32'h0000_0000);
      chk("t6_frac_data", log_data[7], 32'h0000_0000);
`ifdef FPU_CVT_EXCEPT_EN
      chk("t6_nan_exc", 32'(log_exc[0]), 32'h1);
      chk("t6_2p31_exc", 32'(log_exc[1]), 32'h1);
      chk("t6_m2p31_exc", 32'(log_exc[2]), 32'h0);
      chk("t6_max_exc", 32'(log_exc[3]), 32'h0);
      chk("t6_inf_exc", 32'(log_exc[4]), 32'h1);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
